// File: rtl/gfx_pkg.sv
// Shared types for the graphics bypass write path: ownership encoding and the bypass beat layout.
package gfx_pkg;

    localparam int GFX_ADDR_W = 32;
    localparam int GFX_DATA_W = 32;
    localparam int GFX_WE_W   = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_FILL = 2'd1,
        OWN_LINE = 2'd2
    } owner_e;

    typedef struct packed {
        logic [GFX_ADDR_W-1:0] addr;
        logic [GFX_DATA_W-1:0] din;
        logic [GFX_WE_W-1:0]   we;
    } byp_beat_t;

    // Peer engine of a real owner; callers never pass OWN_NONE.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_FILL) ? OWN_LINE : OWN_FILL;
    endfunction

endpackage

// File: rtl/gfx_bypass_arbiter_byp_out_reg.sv
// Single-entry ready/valid pipeline register; accepts a new beat whenever it is empty or being drained.
module byp_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_valid && in_ready) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/gfx_bypass_arbiter.sv
// Round-robin arbiter with burst locking between the filler and line engines for the frame-buffer bypass port.
module gfx_bypass_arbiter
    import gfx_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_din,
    input  logic [3:0]        fill_we,
    input  logic              line_valid,
    output logic              line_ready,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic [DATA_W-1:0] line_din,
    input  logic [3:0]        line_we,
    output logic              byp_valid,
    input  logic              byp_ready,
    output logic [ADDR_W-1:0] byp_addr,
    output logic [DATA_W-1:0] byp_din,
    output logic [3:0]        byp_we,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W:0]   MAX_CNT = (CNT_W + 1)'(MAX_BURST);
    localparam logic [CNT_W-1:0] MAX_SAT = CNT_W'(MAX_BURST);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic [3:0]        we;
    } beat_t;

    owner_e           state_reg, state_next;
    owner_e           last_owner_reg, last_owner_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic [CNT_W:0]   cnt_inc;
    logic             own_valid, other_valid, load_ready, accept;
    beat_t            own_beat, byp_beat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= OWN_NONE;
            last_owner_reg <= OWN_LINE;
            burst_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
            burst_cnt_reg  <= burst_cnt_next;
        end
    end

    assign cnt_inc = {1'b0, burst_cnt_reg} + (CNT_W + 1)'(1);

    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        burst_cnt_next  = burst_cnt_reg;
        case (state_reg)
            OWN_NONE: begin
                burst_cnt_next = '0;
                if (fill_valid && line_valid) begin
                    state_next = other_owner(last_owner_reg);
                end else if (fill_valid) begin
                    state_next = OWN_FILL;
                end else if (line_valid) begin
                    state_next = OWN_LINE;
                end
            end
            OWN_FILL, OWN_LINE: begin
                if (!own_valid) begin
                    state_next      = other_valid ? other_owner(state_reg) : OWN_NONE;
                    last_owner_next = state_reg;
                    burst_cnt_next  = '0;
                end else if (accept) begin
                    // Burst limit only forces a handover when the peer is actually waiting.
                    if (cnt_inc >= MAX_CNT && other_valid) begin
                        state_next      = other_owner(state_reg);
                        last_owner_next = state_reg;
                        burst_cnt_next  = '0;
                    end else begin
                        burst_cnt_next = (cnt_inc >= MAX_CNT) ? MAX_SAT : cnt_inc[CNT_W-1:0];
                    end
                end
            end
            default: state_next = OWN_NONE;
        endcase
    end

    // Only the owner's inputs are steered toward the output register.
    always_comb begin
        own_valid   = 1'b0;
        other_valid = 1'b0;
        own_beat    = '0;
        case (state_reg)
            OWN_FILL: begin
                own_valid   = fill_valid;
                other_valid = line_valid;
                own_beat    = {fill_addr, fill_din, fill_we};
            end
            OWN_LINE: begin
                own_valid   = line_valid;
                other_valid = fill_valid;
                own_beat    = {line_addr, line_din, line_we};
            end
            default: ;
        endcase
        accept     = rst_n && own_valid && load_ready;
        fill_ready = accept && (state_reg == OWN_FILL);
        line_ready = accept && (state_reg == OWN_LINE);
        grant      = {state_reg == OWN_LINE, state_reg == OWN_FILL};
    end

    byp_out_reg #(
        .W($bits(beat_t))
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_ready  (load_ready),
        .in_data   (own_beat),
        .out_valid (byp_valid),
        .out_ready (byp_ready),
        .out_data  (byp_beat)
    );

    assign byp_addr = byp_beat.addr;
    assign byp_din  = byp_beat.din;
    assign byp_we   = byp_beat.we;
    assign busy     = byp_valid | (|grant);

endmodule

// File: tb/tb_gfx_bypass_arbiter.sv
// Bench for gfx_bypass_arbiter: handshake vector table, beat scoreboard and multi-cycle corner sequences.
module tb_gfx_bypass_arbiter;
    import gfx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fill_valid, fill_ready, line_valid, line_ready;
    logic [31:0] fill_addr, fill_din, line_addr, line_din;
    logic [3:0]  fill_we, line_we;
    logic        byp_valid, byp_ready;
    logic [31:0] byp_addr, byp_din;
    logic [3:0]  byp_we;
    logic [1:0]  grant;
    logic        busy;

    always #5 clk = ~clk;

    gfx_bypass_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
        .fill_din(fill_din), .fill_we(fill_we),
        .line_valid(line_valid), .line_ready(line_ready), .line_addr(line_addr),
        .line_din(line_din), .line_we(line_we),
        .byp_valid(byp_valid), .byp_ready(byp_ready), .byp_addr(byp_addr),
        .byp_din(byp_din), .byp_we(byp_we),
        .grant(grant), .busy(busy)
    );

    typedef struct {
        bit         fv, lv, br;
        logic [1:0] g;
        bit         fr, lr, bv;
    } vec_t;

    int        total = 0;
    int        bad   = 0;
    int        fill_n = 0;
    int        line_n = 0;
    int        cyc_idx = 0;
    byp_beat_t sb[$];
    bit        acc_src[$];
    int        pop_cyc[$];
    vec_t      vt[12];

    logic       s_fr, s_lr, s_bv, s_busy;
    logic [1:0] s_grant;
    byp_beat_t  s_beat;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, sample at the falling edge, run the scoreboard, then step past the rising edge.
    task automatic cycle(input bit fv, input bit lv, input bit br, input bit rn = 1'b1);
        byp_beat_t exp_b;
        byp_beat_t fb, lb;
        bit        fa, la;
        rst_n      = rn;
        fill_valid = fv;
        line_valid = lv;
        byp_ready  = br;
        fill_addr  = 32'h100 + 32'(fill_n) * 4;
        fill_din   = 32'hF000_0000 + 32'(fill_n);
        fill_we    = 4'(fill_n);
        line_addr  = 32'h8000 + 32'(line_n) * 4;
        line_din   = 32'hA000_0000 + 32'(line_n);
        line_we    = ~4'(line_n);
        fb = {fill_addr, fill_din, fill_we};
        lb = {line_addr, line_din, line_we};
        @(negedge clk);
        s_fr    = fill_ready;
        s_lr    = line_ready;
        s_bv    = byp_valid;
        s_busy  = busy;
        s_grant = grant;
        s_beat  = {byp_addr, byp_din, byp_we};
        check("occupancy", 128'(byp_valid), 128'(sb.size() != 0));
        if (byp_valid && byp_ready) begin
            if (sb.size() == 0) begin
                check("spurious_beat", 128'(1), 128'(0));
            end else begin
                exp_b = sb.pop_front();
                check("beat", 128'(s_beat), 128'(exp_b));
                pop_cyc.push_back(cyc_idx);
            end
        end
        fa = fill_valid && fill_ready;
        la = line_valid && line_ready;
        if (fa && la) check("dual_accept", 128'(1), 128'(0));
        if (fa) begin
            sb.push_back(fb);
            acc_src.push_back(1'b0);
            fill_n++;
        end
        if (la) begin
            sb.push_back(lb);
            acc_src.push_back(1'b1);
            line_n++;
        end
        @(posedge clk);
        #1;
        cyc_idx++;
        if (!rn) sb.delete();
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        check("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        int cnt;
        vt[0]  = '{fv:0, lv:0, br:1, g:2'b00, fr:0, lr:0, bv:0};
        vt[1]  = '{fv:0, lv:1, br:1, g:2'b00, fr:0, lr:0, bv:0};
        vt[2]  = '{fv:0, lv:1, br:1, g:2'b10, fr:0, lr:1, bv:0};
        vt[3]  = '{fv:0, lv:1, br:0, g:2'b10, fr:0, lr:0, bv:1};
        vt[4]  = '{fv:1, lv:1, br:1, g:2'b10, fr:0, lr:1, bv:1};
        vt[5]  = '{fv:1, lv:0, br:1, g:2'b10, fr:0, lr:0, bv:1};
        vt[6]  = '{fv:1, lv:0, br:1, g:2'b01, fr:1, lr:0, bv:0};
        vt[7]  = '{fv:0, lv:0, br:1, g:2'b01, fr:0, lr:0, bv:1};
        vt[8]  = '{fv:1, lv:1, br:1, g:2'b00, fr:0, lr:0, bv:0};
        vt[9]  = '{fv:1, lv:1, br:1, g:2'b10, fr:0, lr:1, bv:0};
        vt[10] = '{fv:0, lv:0, br:1, g:2'b10, fr:0, lr:0, bv:1};
        vt[11] = '{fv:0, lv:0, br:1, g:2'b00, fr:0, lr:0, bv:0};

        rst_n = 1'b0; fill_valid = 1'b0; line_valid = 1'b0; byp_ready = 1'b0;
        fill_addr = '0; fill_din = '0; fill_we = '0;
        line_addr = '0; line_din = '0; line_we = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with both engines requesting.
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_byp_valid", 128'(s_bv), 128'(0));
        check("rst_grant", 128'(s_grant), 128'(0));
        check("rst_fill_ready", 128'(s_fr), 128'(0));
        check("rst_line_ready", 128'(s_lr), 128'(0));
        cycle(1'b1, 1'b1, 1'b1);
        check("rel_idle_grant", 128'(s_grant), 128'(2'b00));
        cycle(1'b1, 1'b1, 1'b1);
        check("first_owner_fill", 128'(s_grant), 128'(2'b01));
        check("first_fill_ready", 128'(s_fr), 128'(1));
        drain();

        // Handshake vector table from a fresh reset.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(vt[i].fv, vt[i].lv, vt[i].br);
            check($sformatf("vec%0d_grant", i), 128'(s_grant), 128'(vt[i].g));
            check($sformatf("vec%0d_fill_ready", i), 128'(s_fr), 128'(vt[i].fr));
            check($sformatf("vec%0d_line_ready", i), 128'(s_lr), 128'(vt[i].lr));
            check($sformatf("vec%0d_byp_valid", i), 128'(s_bv), 128'(vt[i].bv));
            check($sformatf("vec%0d_busy", i), 128'(s_busy), 128'(vt[i].bv || vt[i].g != 2'b00));
        end
        drain();

        // Five filler beats at full throughput.
        do_reset();
        fill_n = 0;
        pop_cyc.delete();
        cyc_idx = 0;
        for (int k = 0; k < 8; k++) cycle(fill_n < 5, 1'b0, 1'b1);
        check("stream_pops", 128'(pop_cyc.size()), 128'(5));
        if (pop_cyc.size() == 5) begin
            check("stream_first_cycle", 128'(pop_cyc[0]), 128'(2));
            check("stream_last_cycle", 128'(pop_cyc[4]), 128'(6));
        end
        drain();

        // Both engines saturating: 16-beat bursts alternate, filler first.
        do_reset();
        acc_src.delete();
        for (int k = 0; k < 66; k++) cycle(1'b1, 1'b1, 1'b1);
        for (int b = 0; b < 4; b++) begin
            cnt = 0;
            for (int j = 0; j < 16; j++) if (acc_src[b * 16 + j] == bit'(b % 2)) cnt++;
            check($sformatf("burst%0d_len", b), 128'(cnt), 128'(16));
        end
        drain();

        // Memory back-pressure for 7 cycles mid-burst.
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check("stall_valid", 128'(s_bv), 128'(1));
            check("stall_fill_ready", 128'(s_fr), 128'(0));
            if (sb.size() != 0) check("stall_beat_frozen", 128'(s_beat), 128'(sb[0]));
        end
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1);
        drain();

        // Line releases after 3 beats while filler waits; filler gets a full fresh burst.
        do_reset();
        acc_src.delete();
        cycle(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b1);
        cnt = 0;
        foreach (acc_src[j]) if (acc_src[j]) cnt++;
        check("line_beats_before_drop", 128'(cnt), 128'(3));
        cycle(1'b1, 1'b0, 1'b1);
        check("drop_cycle_grant", 128'(s_grant), 128'(2'b10));
        check("drop_cycle_fill_ready", 128'(s_fr), 128'(0));
        acc_src.delete();
        cycle(1'b1, 1'b1, 1'b1);
        check("switch_grant_fill", 128'(s_grant), 128'(2'b01));
        check("switch_fill_ready", 128'(s_fr), 128'(1));
        for (int k = 0; k < 20; k++) cycle(1'b1, 1'b1, 1'b1);
        cnt = 0;
        for (int j = 0; j < 16; j++) if (!acc_src[j]) cnt++;
        check("fill_fresh_burst", 128'(cnt), 128'(16));
        check("line_after_burst", 128'(acc_src[16]), 128'(1));
        drain();

        // Reset while a beat is stuck in the output register.
        do_reset();
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_hold_valid_before", 128'(s_bv), 128'(1));
        check("rst_gate_ready", 128'(s_fr), 128'(0));
        cycle(1'b1, 1'b0, 1'b0);
        check("rst_drop_valid", 128'(s_bv), 128'(0));
        check("rst_drop_grant", 128'(s_grant), 128'(2'b00));
        check("rst_drop_busy", 128'(s_busy), 128'(0));
        cycle(1'b1, 1'b0, 1'b1);
        check("rst_after_owner", 128'(s_grant), 128'(2'b01));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
